// File: rtl/run_monitor_pkg.sv
// rtl/run_monitor_pkg.sv - shared types and constants for the run/exit monitor
// Purpose: run-control FSM state encoding and halt-reason codes.
package run_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RST  = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  localparam logic [1:0] REASON_NONE    = 2'd0;
  localparam logic [1:0] REASON_EXIT    = 2'd1;
  localparam logic [1:0] REASON_TIMEOUT = 2'd2;
  localparam logic [1:0] REASON_ABORT   = 2'd3;

endpackage

// File: rtl/run_monitor_chan.sv
// rtl/run_monitor_chan.sv - one probe channel: exit-value compare with hold counter
// Purpose: flags hit when the channel has matched for MATCH_HOLD consecutive RUN cycles
//   (the current cycle included).
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   run_en        high while the monitor is in RUN; low clears the hold counter
//   ch_en         channel enable
//   probe_valid   probe word valid this cycle
//   probe_data    probe word
//   exit_val      programmed exit value
//   hit           exit condition reached on this channel this cycle
module run_monitor_chan #(
  parameter int DATA_W     = 32,
  parameter int MATCH_HOLD = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run_en,
  input  logic              ch_en,
  input  logic              probe_valid,
  input  logic [DATA_W-1:0] probe_data,
  input  logic [DATA_W-1:0] exit_val,
  output logic              hit
);

  localparam int HOLD_W = $clog2(MATCH_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MATCH_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MATCH_HOLD - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              match;

  assign match = ch_en && probe_valid && (probe_data == exit_val);

  always_comb begin
    hold_d = hold_q;
    if (!run_en || !match) begin
      hold_d = '0;
    end else if (hold_q != HOLD_MAX) begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  // The counter reaches MATCH_HOLD on this edge, so exit is declared in the matching cycle itself.
  assign hit = run_en && match && ((hold_q == HOLD_LAST) || (hold_q == HOLD_MAX));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

endmodule

// File: rtl/run_monitor.sv
// rtl/run_monitor.sv - core run sequencer, cycle counter and exit/timeout/abort monitor
// Purpose: pulses the core reset, counts RUN cycles, halts on exit match, timeout or abort.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   start, clear      run start pulse, HALT->IDLE pulse
//   abort             level, forces halt while running
//   cfg_ch_en, cfg_exit_val, cfg_timeout   channel mask, exit values, run-cycle limit (0 = none)
//   probe_valid, probe_data                per-channel probe words
//   cpu_reset, running, halted, halt_pulse status outputs (all registered)
//   halt_reason, halt_ch, cycle_count      halt report
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 32,
  parameter int RST_CYCLES = 2,
  parameter int MATCH_HOLD = 1,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     clear,
  input  logic [NUM_CH-1:0]        cfg_ch_en,
  input  logic [NUM_CH*DATA_W-1:0] cfg_exit_val,
  input  logic [CNT_W-1:0]         cfg_timeout,
  input  logic [NUM_CH-1:0]        probe_valid,
  input  logic [NUM_CH*DATA_W-1:0] probe_data,
  output logic                     cpu_reset,
  output logic                     running,
  output logic                     halted,
  output logic                     halt_pulse,
  output logic [1:0]               halt_reason,
  output logic [CH_W-1:0]          halt_ch,
  output logic [CNT_W-1:0]         cycle_count
);

  localparam int RCNT_W = $clog2(RST_CYCLES + 1);
  localparam logic [RCNT_W-1:0] RST_LAST = RCNT_W'(RST_CYCLES - 1);

  state_e            state_q, state_d;
  logic [RCNT_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
  logic [1:0]        halt_reason_q, halt_reason_d;
  logic [CH_W-1:0]   halt_ch_q, halt_ch_d;
  logic              halt_pulse_q, halt_pulse_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              running_q, running_d;
  logic              halted_q, halted_d;

  logic [NUM_CH-1:0] hit;
  logic              exit_hit;
  logic [CH_W-1:0]   exit_ch;
  logic              timeout_hit;
  logic              run_en;

  assign run_en = (state_q == ST_RUN);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    run_monitor_chan #(
      .DATA_W     (DATA_W),
      .MATCH_HOLD (MATCH_HOLD)
    ) u_chan (
      .clk         (clk),
      .reset_n     (reset_n),
      .run_en      (run_en),
      .ch_en       (cfg_ch_en[i]),
      .probe_valid (probe_valid[i]),
      .probe_data  (probe_data[i*DATA_W +: DATA_W]),
      .exit_val    (cfg_exit_val[i*DATA_W +: DATA_W]),
      .hit         (hit[i])
    );
  end

  // Scan from the top so the lowest hitting channel is the one left standing.
  always_comb begin
    exit_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (hit[i]) exit_ch = CH_W'(i);
    end
  end

  assign exit_hit    = |hit;
  assign timeout_hit = (cfg_timeout != '0) && (cycle_count_q == cfg_timeout - CNT_W'(1));

  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    cycle_count_d = cycle_count_q;
    halt_reason_d = halt_reason_q;
    halt_ch_d     = halt_ch_q;
    halt_pulse_d  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d       = ST_RST;
          rst_cnt_d     = '0;
          cycle_count_d = '0;
          halt_reason_d = REASON_NONE;
          halt_ch_d     = '0;
        end else if (clear && (state_q == ST_HALT)) begin
          state_d = ST_IDLE;
        end
      end
      ST_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = ST_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + RCNT_W'(1);
        end
      end
      ST_RUN: begin
        if (abort || exit_hit || timeout_hit) begin
          state_d      = ST_HALT;
          halt_pulse_d = 1'b1;
          halt_ch_d    = '0;
          if (abort) begin
            halt_reason_d = REASON_ABORT;
          end else if (exit_hit) begin
            halt_reason_d = REASON_EXIT;
            halt_ch_d     = exit_ch;
          end else begin
            halt_reason_d = REASON_TIMEOUT;
          end
        end else if (cycle_count_q != '1) begin
          cycle_count_d = cycle_count_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    cpu_reset_d = (state_d == ST_IDLE) || (state_d == ST_RST);
    running_d   = (state_d == ST_RUN);
    halted_d    = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      rst_cnt_q     <= '0;
      cycle_count_q <= '0;
      halt_reason_q <= REASON_NONE;
      halt_ch_q     <= '0;
      halt_pulse_q  <= 1'b0;
      cpu_reset_q   <= 1'b1;
      running_q     <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      cycle_count_q <= cycle_count_d;
      halt_reason_q <= halt_reason_d;
      halt_ch_q     <= halt_ch_d;
      halt_pulse_q  <= halt_pulse_d;
      cpu_reset_q   <= cpu_reset_d;
      running_q     <= running_d;
      halted_q      <= halted_d;
    end
  end

  assign cpu_reset   = cpu_reset_q;
  assign running     = running_q;
  assign halted      = halted_q;
  assign halt_pulse  = halt_pulse_q;
  assign halt_reason = halt_reason_q;
  assign halt_ch     = halt_ch_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_run_monitor.sv
// tb/tb_run_monitor.sv - scoreboard bench for run_monitor (two parameterisations, shared stimulus)
module tb_run_monitor;

  localparam int MAXK = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n, start, abort, clear;
  logic [3:0]   cfg_ch_en, probe_valid;
  logic [127:0] cfg_exit_val, probe_data;
  logic [31:0]  cfg_timeout_a;
  logic [3:0]   cfg_timeout_b;

  logic         cpu_reset_a, running_a, halted_a, halt_pulse_a;
  logic [1:0]   halt_reason_a, halt_ch_a;
  logic [31:0]  cycle_count_a;
  logic         cpu_reset_b, running_b, halted_b, halt_pulse_b;
  logic [1:0]   halt_reason_b, halt_ch_b;
  logic [3:0]   cycle_count_b;

  run_monitor #(.NUM_CH(4), .DATA_W(32), .CNT_W(32), .RST_CYCLES(2), .MATCH_HOLD(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .clear(clear),
    .cfg_ch_en(cfg_ch_en), .cfg_exit_val(cfg_exit_val), .cfg_timeout(cfg_timeout_a),
    .probe_valid(probe_valid), .probe_data(probe_data),
    .cpu_reset(cpu_reset_a), .running(running_a), .halted(halted_a), .halt_pulse(halt_pulse_a),
    .halt_reason(halt_reason_a), .halt_ch(halt_ch_a), .cycle_count(cycle_count_a)
  );

  run_monitor #(.NUM_CH(4), .DATA_W(32), .CNT_W(4), .RST_CYCLES(2), .MATCH_HOLD(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .clear(clear),
    .cfg_ch_en(cfg_ch_en), .cfg_exit_val(cfg_exit_val), .cfg_timeout(cfg_timeout_b),
    .probe_valid(probe_valid), .probe_data(probe_data),
    .cpu_reset(cpu_reset_b), .running(running_b), .halted(halted_b), .halt_pulse(halt_pulse_b),
    .halt_reason(halt_reason_b), .halt_ch(halt_ch_b), .cycle_count(cycle_count_b)
  );

  typedef struct {
    int     rsn;
    int     ch;
    longint cnt;
    int     len;
  } exp_t;

  exp_t         q_a[$];
  exp_t         q_b[$];
  logic [3:0]   s_valid [MAXK];
  logic [127:0] s_data  [MAXK];
  int           abort_k, sc_k;
  bit           pend_clear;
  int           n_checks = 0;
  int           n_fail   = 0;
  int           run_len [2];
  bit           prev_hp [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: walk the RUN cycles of the scheduled stimulus and find the first halt.
  task automatic model(input int hold, input longint cmax, input longint to,
                       output int hk, output int rsn, output int ch, output longint cnt);
    int     h [4];
    longint c;
    bit     ex;
    int     exch;
    hk = -1; rsn = 0; ch = 0; cnt = 0;
    foreach (h[i]) h[i] = 0;
    for (int k = 0; k < MAXK; k++) begin
      c  = (k < cmax) ? longint'(k) : cmax;
      ex = 0; exch = 0;
      for (int i = 3; i >= 0; i--) begin
        if (cfg_ch_en[i] && s_valid[k][i] && s_data[k][i*32 +: 32] == cfg_exit_val[i*32 +: 32])
          h[i] = (h[i] < hold) ? h[i] + 1 : hold;
        else
          h[i] = 0;
        if (h[i] == hold) begin ex = 1; exch = i; end
      end
      if (k == abort_k) begin rsn = 3; ch = 0; end
      else if (ex) begin rsn = 1; ch = exch; end
      else if (to != 0 && c == to - 1) begin rsn = 2; ch = 0; end
      if (rsn != 0) begin hk = k; cnt = c; return; end
    end
  endtask

  task automatic mon(input int id, input logic hp, input logic run, input logic crst, input logic hlt,
                     input logic [1:0] rsn, input logic [1:0] ch, input logic [63:0] cnt);
    exp_t e;
    bit   empty;
    if (prev_hp[id]) check($sformatf("pulse_width_%0d", id), 64'(hp), 64'd0);
    prev_hp[id] = hp;
    if (crst) run_len[id] = 0;
    else if (run) run_len[id]++;
    if (hp === 1'b1) begin
      empty = (id == 0) ? (q_a.size() == 0) : (q_b.size() == 0);
      if (empty) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_halt_%0d: got reason %0d expected no halt", id, rsn);
      end else begin
        if (id == 0) e = q_a.pop_front(); else e = q_b.pop_front();
        check($sformatf("reason_%0d", id), 64'(rsn), 64'(e.rsn));
        check($sformatf("halt_ch_%0d", id), 64'(ch), 64'(e.ch));
        check($sformatf("count_%0d", id), cnt, 64'(e.cnt));
        check($sformatf("run_len_%0d", id), 64'(run_len[id]), 64'(e.len));
        check($sformatf("halted_%0d", id), 64'(hlt), 64'd1);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, halt_pulse_a, running_a, cpu_reset_a, halted_a, halt_reason_a, halt_ch_a, 64'(cycle_count_a));
    mon(1, halt_pulse_b, running_b, cpu_reset_b, halted_b, halt_reason_b, halt_ch_b, 64'(cycle_count_b));
  end

  task automatic clear_sched();
    for (int k = 0; k < MAXK; k++) begin
      s_valid[k] = '0;
      s_data[k]  = '0;
    end
    abort_k = -1;
    sc_k    = -1;
  endtask

  task automatic run_both();
    int hka, ra, cha, hkb, rb, chb, last, mode;
    longint cnta, cntb;
    model(1, 64'hFFFF_FFFF, longint'(cfg_timeout_a), hka, ra, cha, cnta);
    model(3, 15, longint'(cfg_timeout_b), hkb, rb, chb, cntb);
    if (hka >= 0) q_a.push_back('{ra, cha, cnta, hka + 1});
    if (hkb >= 0) q_b.push_back('{rb, chb, cntb, hkb + 1});
    last = (hka < 0 || hkb < 0) ? MAXK - 1 : ((hka > hkb) ? hka : hkb);
    @(posedge clk); #1 start = 1'b1; clear = pend_clear; pend_clear = 0;
    @(posedge clk); #1 start = 1'b0; clear = 1'b0;
    @(negedge clk);
    check("rst1_cpu_reset", 64'(cpu_reset_a), 64'd1);
    check("rst1_halted", 64'(halted_a), 64'd0);
    check("rst1_reason_a", 64'(halt_reason_a), 64'd0);
    check("rst1_count_a", 64'(cycle_count_a), 64'd0);
    check("rst1_count_b", 64'(cycle_count_b), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst2_hold", 64'({cpu_reset_a, running_a, cpu_reset_b}), 64'b101);
    for (int k = 0; k <= last; k++) begin
      @(posedge clk); #1;
      probe_valid = s_valid[k];
      probe_data  = s_data[k];
      abort       = (k == abort_k);
      start       = (k == sc_k);
      clear       = (k == sc_k);
      if (k == 0) begin
        @(negedge clk);
        check("run0_state", 64'({running_a, cpu_reset_a}), 64'b10);
        check("run0_count", 64'(cycle_count_a), 64'd0);
      end
    end
    @(posedge clk); #1;
    probe_valid = '0; abort = 1'b0; start = 1'b0; clear = 1'b0;
    @(negedge clk);
    check("halted_after_a", 64'(halted_a), 64'(hka >= 0));
    check("halted_after_b", 64'(halted_b), 64'(hkb >= 0));
    mode = $urandom_range(0, 2);
    if (mode == 0 && hka >= 0 && hkb >= 0) begin
      @(posedge clk); #1 clear = 1'b1;
      @(posedge clk); #1 clear = 1'b0;
      @(negedge clk);
      check("clear_state_a", 64'({halted_a, cpu_reset_a}), 64'b01);
      check("clear_keep_reason_a", 64'(halt_reason_a), 64'(ra));
      check("clear_keep_count_a", 64'(cycle_count_a), 64'(cnta));
      check("clear_keep_count_b", 64'(cycle_count_b), 64'(cntb));
    end else if (mode == 2) begin
      pend_clear = 1;
    end
  endtask

  task automatic gen_random();
    cfg_ch_en = 4'($urandom_range(0, 15));
    for (int i = 0; i < 4; i++) cfg_exit_val[i*32 +: 32] = $urandom_range(0, 3);
    cfg_timeout_a = $urandom_range(1, 40);
    cfg_timeout_b = 4'($urandom_range(1, 15));
    abort_k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1;
    sc_k = -1;
    for (int k = 0; k < MAXK; k++) begin
      s_valid[k] = 4'($urandom & $urandom);
      for (int i = 0; i < 4; i++) s_data[k][i*32 +: 32] = $urandom_range(0, 3);
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; clear = 1'b0;
    cfg_ch_en = '0; cfg_exit_val = '0; cfg_timeout_a = '0; cfg_timeout_b = '0;
    probe_valid = '0; probe_data = '0; pend_clear = 0;
    clear_sched();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_cpu_reset", 64'(cpu_reset_a), 64'd1);
    check("reset_status", 64'({running_a, halted_a, halt_pulse_a}), 64'd0);
    check("reset_reason_ch", 64'({halt_reason_a, halt_ch_a}), 64'd0);
    check("reset_count", 64'(cycle_count_a), 64'd0);
    reset_n = 1'b1;

    // Exit on ch0 at RUN cycle 10; the hold-3 instance never qualifies and is aborted later.
    clear_sched();
    cfg_ch_en = 4'b0001; cfg_exit_val = '0; cfg_exit_val[31:0] = 32'd25;
    cfg_timeout_a = 0; cfg_timeout_b = 0;
    s_valid[10] = 4'b0001; s_data[10][31:0] = 32'd25; abort_k = 30;
    run_both();
    pend_clear = 1;

    // Timeout only.
    clear_sched();
    cfg_ch_en = 4'b0000; cfg_timeout_a = 50; cfg_timeout_b = 9;
    run_both();

    // ch1 and ch3 match in the timeout cycle, then the same with abort added.
    clear_sched();
    cfg_ch_en = 4'b1010; cfg_exit_val = '0;
    cfg_exit_val[63:32] = 32'd7; cfg_exit_val[127:96] = 32'd9;
    cfg_timeout_a = 8; cfg_timeout_b = 8;
    s_valid[7] = 4'b1010; s_data[7][63:32] = 32'd7; s_data[7][127:96] = 32'd9;
    run_both();
    abort_k = 7;
    run_both();

    // Match 2, miss 1, match 3.
    clear_sched();
    cfg_ch_en = 4'b0001; cfg_exit_val = '0; cfg_exit_val[31:0] = 32'd5;
    cfg_timeout_a = 0; cfg_timeout_b = 0;
    foreach (s_valid[k]) if (k >= 2 && k <= 7) begin
      s_valid[k] = 4'b0001;
      s_data[k][31:0] = (k == 4) ? 32'd6 : 32'd5;
    end
    run_both();

    // Long run, no timeout: narrow counter saturates, start+clear mid-run ignored.
    clear_sched();
    cfg_ch_en = 4'b0000; cfg_timeout_a = 0; cfg_timeout_b = 0;
    abort_k = 20; sc_k = 12;
    run_both();

    // Asynchronous reset in the middle of a run.
    clear_sched();
    cfg_ch_en = 4'b0000; cfg_timeout_a = 0; cfg_timeout_b = 0;
    @(posedge clk); #1 start = 1'b1; clear = pend_clear; pend_clear = 0;
    @(posedge clk); #1 start = 1'b0; clear = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    check("pre_reset_running", 64'(running_a), 64'd1);
    #1 reset_n = 1'b0;
    #1;
    check("mid_reset_state", 64'({cpu_reset_a, running_a, halted_a}), 64'b100);
    check("mid_reset_count_a", 64'(cycle_count_a), 64'd0);
    check("mid_reset_count_b", 64'(cycle_count_b), 64'd0);
    @(negedge clk); reset_n = 1'b1;

    for (int r = 0; r < 25; r++) begin
      gen_random();
      run_both();
    end

    for (int w = 0; w < 100 && (q_a.size() != 0 || q_b.size() != 0); w++) @(negedge clk);
    check("drained_a", 64'(q_a.size()), 64'd0);
    check("drained_b", 64'(q_b.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
